// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared RS232 defaults, receiver state type and baud increment helper
package uart_receiver_pkg;

  // RS232 line defaults, shared with the transmit-side baud generator
  localparam int RS232_CLK_FREQUENCY = 50_000_000;
  localparam int RS232_BAUD          = 115_200;
  localparam int RS232_OVERSAMPLING  = 8;
  localparam int RS232_ACC_WIDTH     = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Rounded phase increment: ((baud * oversampling) << acc_w) / clk_hz
  function automatic longint unsigned calc_inc(input longint unsigned clk_hz,
                                               input longint unsigned baud_hz,
                                               input longint unsigned os,
                                               input int              acc_w);
    longint unsigned num;
    num = (baud_hz * os) << acc_w;
    return (num + (clk_hz / 2)) / clk_hz;
  endfunction

endpackage

// File: rtl/uart_receiver_baud_oversample_generator.sv
// rtl/uart_receiver_baud_oversample_generator.sv - free-running phase accumulator producing the oversample tick
module baud_oversample_generator
  import uart_receiver_pkg::*;
#(
  parameter int clkFrequency = RS232_CLK_FREQUENCY,
  parameter int baud         = RS232_BAUD,
  parameter int oversampling = RS232_OVERSAMPLING,
  parameter int accWidth     = RS232_ACC_WIDTH
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam longint unsigned INC_L = calc_inc(longint'(clkFrequency), longint'(baud),
                                               longint'(oversampling), accWidth);
  localparam logic [accWidth:0] INC = INC_L[accWidth:0];

  logic [accWidth:0] acc;

  // Add the increment to the low bits; the carry lands in the top bit and is the tick
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[accWidth-1:0]} + INC;
    end
  end

  assign tick = acc[accWidth];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with oversampled mid-bit sampling and framing check
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int clkFrequency = RS232_CLK_FREQUENCY,
  parameter int baud         = RS232_BAUD,
  parameter int oversampling = RS232_OVERSAMPLING,
  parameter int accWidth     = RS232_ACC_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int            CW   = $clog2(oversampling);
  localparam logic [CW-1:0] HALF = CW'(oversampling / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(oversampling - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          tick;
  logic [1:0]    sync_q;
  logic          line;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  baud_oversample_generator #(
    .clkFrequency(clkFrequency),
    .baud        (baud),
    .oversampling(oversampling),
    .accWidth    (accWidth)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign line    = sync_q[1];
  assign rx_busy = (state != IDLE);

  // Frame FSM: advances and samples only on oversample ticks; pulses are one clk wide
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_data       <= 8'h00;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!line) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            // Half a bit into the start bit: still low means a real frame
            if (cnt == HALF) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= line ? IDLE : DATA;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          DATA: begin
            if (cnt == FULL) begin
              cnt   <= '0;
              shift <= {line, shift[7:1]};
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              cnt <= cnt + ONE;
            end
          end
          STOP: begin
            if (cnt == FULL) begin
              cnt <= '0;
              if (line) begin
                rx_data    <= shift;
                data_ready <= 1'b1;
                state      <= IDLE;
              end else begin
                framing_error <= 1'b1;
                state         <= WAIT_IDLE;
              end
            end else begin
              cnt <= cnt + ONE;
            end
          end
          WAIT_IDLE: begin
            // Hold through a break so it reports only one framing error
            if (line) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver
module tb_uart_receiver;

  localparam int BIT_CLK  = 434;
  localparam int FAST_CLK = 425;
  localparam int SLOW_CLK = 443;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       framing_error;
  logic       rx_busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int dr_count     = 0;
  int fe_count     = 0;

  logic [7:0] exp_q[$];

  uart_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Scoreboard: every data_ready pops the oldest expected byte
  always @(negedge clk) begin
    if (!reset) begin
      if (data_ready) begin
        dr_count = dr_count + 1;
        tests_run = tests_run + 1;
        if (exp_q.size() == 0) begin
          tests_failed = tests_failed + 1;
          $display("FAIL unexpected_data_ready: rx_data=%02h, nothing expected", rx_data);
        end else begin
          logic [7:0] exp_b;
          exp_b = exp_q.pop_front();
          if (rx_data !== exp_b) begin
            tests_failed = tests_failed + 1;
            $display("FAIL rx_data: got %02h expected %02h", rx_data, exp_b);
          end
        end
      end
      if (framing_error) fe_count = fe_count + 1;
      if (data_ready && framing_error) begin
        tests_run = tests_run + 1;
        tests_failed = tests_failed + 1;
        $display("FAIL both_pulses: data_ready and framing_error high together");
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int cpb);
    rxd = 1'b0;
    wait_clks(cpb);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(cpb);
    end
    rxd = 1'b1;
    wait_clks(cpb);
  endtask

  task automatic test_reset;
    rxd   = 1'b1;
    reset = 1'b1;
    wait_clks(5);
    reset = 1'b0;
    @(negedge clk);
    tests_run = tests_run + 4;
    if (rx_data !== 8'h00) begin
      tests_failed++; $display("FAIL reset_rx_data: got %02h expected 00", rx_data);
    end
    if (data_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_data_ready: got %b expected 0", data_ready);
    end
    if (framing_error !== 1'b0) begin
      tests_failed++; $display("FAIL reset_framing_error: got %b expected 0", framing_error);
    end
    if (rx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy);
    end
    wait_clks(2 * BIT_CLK);
  endtask

  task automatic test_byte;
    int dr0, fe0;
    dr0 = dr_count; fe0 = fe_count;
    exp_q.push_back(8'h55);
    send_byte(8'h55, BIT_CLK);
    wait_clks(BIT_CLK);
    tests_run = tests_run + 2;
    if (dr_count - dr0 != 1) begin
      tests_failed++; $display("FAIL byte_pulses: got %0d expected 1", dr_count - dr0);
    end
    if (fe_count != fe0) begin
      tests_failed++; $display("FAIL byte_framing: got %0d errors expected 0", fe_count - fe0);
    end
  endtask

  task automatic test_glitch;
    int dr0;
    dr0 = dr_count;
    rxd = 1'b0;
    wait_clks(100);
    rxd = 1'b1;
    wait_clks(BIT_CLK);
    tests_run = tests_run + 2;
    if (rx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL glitch_busy: got %b expected 0", rx_busy);
    end
    if (dr_count != dr0) begin
      tests_failed++; $display("FAIL glitch_pulses: got %0d expected 0", dr_count - dr0);
    end
    wait_clks(BIT_CLK);
  endtask

  task automatic test_break;
    int fe0;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, BIT_CLK);
    wait_clks(BIT_CLK);
    fe0 = fe_count;
    rxd = 1'b0;
    wait_clks(20 * BIT_CLK);
    tests_run = tests_run + 3;
    if (rx_busy !== 1'b1) begin
      tests_failed++; $display("FAIL break_busy_low_line: got %b expected 1", rx_busy);
    end
    if (fe_count - fe0 != 1) begin
      tests_failed++; $display("FAIL break_fe_count: got %0d expected 1", fe_count - fe0);
    end
    if (rx_data !== 8'h3C) begin
      tests_failed++; $display("FAIL break_rx_data: got %02h expected 3c", rx_data);
    end
    rxd = 1'b1;
    wait_clks(BIT_CLK);
    tests_run = tests_run + 2;
    if (rx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL break_busy_after_rise: got %b expected 0", rx_busy);
    end
    if (fe_count - fe0 != 1) begin
      tests_failed++; $display("FAIL break_fe_after_rise: got %0d expected 1", fe_count - fe0);
    end
    wait_clks(BIT_CLK);
  endtask

  task automatic test_back_to_back;
    int dr0;
    dr0 = dr_count;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h0F);
    send_byte(8'hA5, BIT_CLK);
    send_byte(8'h0F, BIT_CLK);
    wait_clks(BIT_CLK);
    tests_run = tests_run + 2;
    if (dr_count - dr0 != 2) begin
      tests_failed++; $display("FAIL b2b_pulses: got %0d expected 2", dr_count - dr0);
    end
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL b2b_pending: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_rate_tolerance;
    int dr0, fe0;
    logic [7:0] pats [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    int         rates[4] = '{FAST_CLK, FAST_CLK, SLOW_CLK, SLOW_CLK};
    dr0 = dr_count; fe0 = fe_count;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pats[i]);
      send_byte(pats[i], rates[i]);
      wait_clks(BIT_CLK);
    end
    tests_run = tests_run + 2;
    if (dr_count - dr0 != 4) begin
      tests_failed++; $display("FAIL rate_pulses: got %0d expected 4", dr_count - dr0);
    end
    if (fe_count != fe0) begin
      tests_failed++; $display("FAIL rate_framing: got %0d errors expected 0", fe_count - fe0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int dr0;
    logic [7:0] b;
    b = 8'h81;
    dr0 = dr_count;
    rxd = 1'b0;
    wait_clks(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      wait_clks(BIT_CLK);
    end
    rxd = b[3];
    wait_clks(BIT_CLK / 2);
    reset = 1'b1;
    wait_clks(3);
    rxd   = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    tests_run = tests_run + 2;
    if (rx_data !== 8'h00) begin
      tests_failed++; $display("FAIL midreset_rx_data: got %02h expected 00", rx_data);
    end
    if (rx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_busy: got %b expected 0", rx_busy);
    end
    wait_clks(12 * BIT_CLK);
    tests_run = tests_run + 1;
    if (dr_count != dr0) begin
      tests_failed++; $display("FAIL midreset_no_pulse: got %0d expected 0", dr_count - dr0);
    end
    exp_q.push_back(8'h42);
    send_byte(8'h42, BIT_CLK);
    wait_clks(BIT_CLK);
    tests_run = tests_run + 2;
    if (dr_count - dr0 != 1) begin
      tests_failed++; $display("FAIL midreset_pulses: got %0d expected 1", dr_count - dr0);
    end
    if (rx_data !== 8'h42) begin
      tests_failed++; $display("FAIL midreset_final_data: got %02h expected 42", rx_data);
    end
  endtask

  initial begin
    rxd   = 1'b1;
    reset = 1'b1;
    test_reset();
    test_byte();
    test_glitch();
    test_break();
    test_back_to_back();
    test_rate_tolerance();
    test_reset_mid_frame();
    tests_run = tests_run + 1;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter clkFrequency, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baud, default 115200, line bit rate.
REQ-003 SHALL have parameter oversampling, default 8, oversample ticks per bit period (power of two, at least 4).
REQ-004 SHALL have parameter accWidth, default 16, phase-accumulator width.
REQ-005 SHALL have port clk, input, 1, sole clock, all logic rising-edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port rx_data, output, 8, last correctly framed byte.
REQ-009 SHALL have port data_ready, output, 1, one-clk pulse when rx_data is updated.
REQ-010 SHALL have port framing_error, output, 1, one-clk pulse when the stop bit is sampled low.
REQ-011 SHALL have port rx_busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL generate an oversample tick: (accWidth+1)-bit accumulator adds inc = round((baud*oversampling)<<accWidth / clkFrequency) to its low accWidth bits every clk, and the tick is the carry bit (1208 at defaults, about 921.6 kHz).
REQ-013 SHALL pass rxd through a 2-flop synchronizer before any use, giving 2 clk of input latency.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE, with all state changes and line samples taken only on tick cycles.
REQ-015 SHALL, in IDLE, enter START on the first tick that sees the synchronized line low, and clear the tick counter.
REQ-016 SHALL, in START, resample the line after oversampling/2 ticks: low enters DATA with the counter cleared; high is a false start and returns to IDLE with no output.
REQ-017 SHALL, in DATA, sample the line every oversampling ticks and shift 8 bits LSB-first into a shift register, then enter STOP after bit 7.
REQ-018 SHALL, in STOP, sample the line oversampling ticks after bit 7.
REQ-019 SHALL, on a high stop bit, load rx_data from the shift register, pulse data_ready for exactly 1 clk on that cycle, and return to IDLE.
REQ-020 SHALL, on a low stop bit, pulse framing_error for 1 clk, leave rx_data unchanged, and enter WAIT_IDLE.
REQ-021 SHALL leave WAIT_IDLE for IDLE only on a tick that sees the line high, so a break yields exactly one framing_error.
REQ-022 SHALL never assert data_ready and framing_error on the same cycle.
REQ-023 SHALL have no receive buffer: a new byte overwrites rx_data, data_ready pulses again, and no overrun is flagged.
REQ-024 SHALL let the tick counter wrap only by explicit clear, never by overflow.
REQ-025 SHALL keep the accumulator free-running, never resynchronized to frame edges.

Reset
REQ-026 SHALL, on reset, set state=IDLE, accumulator=0, counters=0, shift register=0, rx_data=8'h00, data_ready=0, framing_error=0, and synchronizer flops=1.
REQ-027 SHALL treat reset asserted mid-frame as abandoning the frame with no pulse; reception restarts on the next falling edge after release.

Structure
REQ-028 SHALL take default clkFrequency, baud, oversampling and accWidth from the shared RS232 defines include, the same one used by the transmit-side baud generator.
REQ-029 SHALL place the accumulator tick in one sub-module, baud_oversample_generator (clk, reset, tick); the rest stays in uart_receiver.

Verification
REQ-030 SHALL verify a byte receive: drive 0x55 at 115200 8N1 (434 clk/bit) -> one data_ready pulse, rx_data=0x55, framing_error never high.
REQ-031 SHALL verify glitch rejection: rxd low for 100 clk, then high -> no data_ready, rx_busy returns low within 1 bit time.
REQ-032 SHALL verify break handling: rxd low for 20 bit times after a prior 0x3C -> exactly one framing_error, rx_data stays 0x3C, rx_busy high until rxd rises.
REQ-033 SHALL verify back-to-back frames: 0xA5 then 0x0F with no idle gap -> two data_ready pulses carrying 0xA5 then 0x0F.
REQ-034 SHALL verify rate tolerance: sender at +2% and -2% baud sending 0xFF and 0x00 -> both received correctly.
REQ-035 SHALL verify reset mid-frame: reset pulsed during bit 3 of 0x81, then a fresh 0x42 -> no pulse for 0x81, then data_ready with rx_data=0x42.
